twoscomp_lanes: RTL and testbench

Parametrised, pipelined multi-lane two's-complement unit for the extended DLX datapath: a fixed single-mode 16-bit negator extended to LANES independent signed lanes of WIDTH bits. Modes are pass, negate, absolute value and negative-absolute, with per-lane enable, overflow detection on the most-negative value and optional saturation. Inputs and outputs use valid/ready handshakes through a 2-stage pipeline, and a saturating overflow event counter is provided for the TinyML extension's debug CSR.

---
 rtl/twoscomp_lanes_if.sv | 33 +++
 rtl/twoscomp_lanes.sv | 140 ++++++++++++++
 tb/tb_twoscomp_lanes.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/twoscomp_lanes_if.sv
// Valid/ready bundle for the multi-lane two's-complement unit.
// Carries the input beat, the output beat and the overflow counter port.
interface twoscomp_lanes_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int CNT_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*WIDTH-1:0]   in_data;
  logic [1:0]               in_mode;
  logic [LANES-1:0]         in_en;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*WIDTH-1:0]   out_data;
  logic [LANES-1:0]         out_ovf;
  logic [CNT_W-1:0]         ovf_count;
  logic                     ovf_clr;

  modport master (
    output in_valid, in_data, in_mode, in_en,
    output out_ready, ovf_clr,
    input  in_ready, out_valid, out_data,
    input  out_ovf, ovf_count
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_en,
    input  out_ready, ovf_clr,
    output in_ready, out_valid, out_data,
    output out_ovf, ovf_count
  );
endinterface

// File: rtl/twoscomp_lanes.sv
// Pipelined LANES x WIDTH two's-complement unit: pass/neg/abs/-abs
// with MIN-overflow detection, optional saturation and an event counter.
module twoscomp_lanes #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int SAT   = 1,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  twoscomp_lanes_if.slave bus
);
  localparam int DW = LANES * WIDTH;
  localparam int PW = $clog2(LANES + 1);
  localparam int SW = CNT_W + PW;
  localparam logic [WIDTH-1:0] MIN =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX = ~MIN;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam bit SAT_EN = (SAT != 0);
  localparam logic [SW-1:0] CMAX =
    SW'({CNT_W{1'b1}});

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [1:0]       mode;
    logic [LANES-1:0] en;
  } s1_t;

  s1_t              r_s1;
  logic             r_s1_valid;
  logic             r_out_valid;
  logic [DW-1:0]    r_out_data;
  logic [LANES-1:0] r_out_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_s2_load;
  logic [DW-1:0]    w_res;
  logic [LANES-1:0] w_ovf;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_neg;
  logic [WIDTH-1:0] w_y;
  logic [PW-1:0]    w_pop;
  logic [SW-1:0]    w_sum;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_s2_adv  = !r_out_valid || bus.out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign w_s2_load = w_s2_adv && r_s1_valid;

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.ovf_count = r_cnt;

  always_comb begin
    w_res = '0;
    w_ovf = '0;
    w_x   = '0;
    w_neg = '0;
    w_y   = '0;
    for (int i = 0; i < LANES; i++) begin
      w_x   = r_s1.data[i*WIDTH +: WIDTH];
      w_neg = ~w_x + ONE;
      w_y   = w_x;
      if (r_s1.en[i]) begin
        unique case (r_s1.mode)
          2'b01: begin
            w_y      = w_neg;
            w_ovf[i] = (w_x == MIN);
          end
          2'b10: begin
            if (w_x[WIDTH-1]) begin
              w_y      = w_neg;
              w_ovf[i] = (w_x == MIN);
            end
          end
          2'b11: begin
            if (!w_x[WIDTH-1] && (w_x != '0))
              w_y = w_neg;
          end
          default: ;
        endcase
      end
      // MIN has no positive twin; clamp to MAX when saturating
      if (w_ovf[i] && SAT_EN)
        w_y = MAX;
      w_res[i*WIDTH +: WIDTH] = w_y;
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++)
      w_pop = w_pop + PW'(w_ovf[i]);
    w_sum     = SW'(r_cnt) + SW'(w_pop);
    w_cnt_nxt = (w_sum > CMAX) ? '1
                               : w_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid)
        r_s1 <= '{data: bus.in_data,
                  mode: bus.in_mode,
                  en:   bus.in_en};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_res;
        r_out_ovf  <= w_ovf;
      end
    end
  end

  // clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (bus.ovf_clr)
      r_cnt <= '0;
    else if (w_s2_load)
      r_cnt <= w_cnt_nxt;
  end
endmodule

// File: tb/tb_twoscomp_lanes.sv
// Bench for twoscomp_lanes: three instances (SAT=1, SAT=0, CNT_W=4)
// share stimulus; each is scored against an integer-arithmetic model.
module tb_twoscomp_lanes;
  localparam int W  = 16;
  localparam int L  = 4;
  localparam int DW = W * L;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [1:0]    in_mode;
  logic [L-1:0]  in_en;
  logic          out_ready;
  logic          ovf_clr;

  always #5 clk = ~clk;

  twoscomp_lanes_if #(.WIDTH(W), .LANES(L), .CNT_W(16)) b1 ();
  twoscomp_lanes_if #(.WIDTH(W), .LANES(L), .CNT_W(16)) b0 ();
  twoscomp_lanes_if #(.WIDTH(W), .LANES(L), .CNT_W(4))  b4 ();

  twoscomp_lanes #(.WIDTH(W), .LANES(L), .SAT(1), .CNT_W(16))
    u_sat (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  twoscomp_lanes #(.WIDTH(W), .LANES(L), .SAT(0), .CNT_W(16))
    u_wrap (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  twoscomp_lanes #(.WIDTH(W), .LANES(L), .SAT(1), .CNT_W(4))
    u_c4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  assign b1.in_valid = in_valid;  assign b0.in_valid = in_valid;
  assign b4.in_valid = in_valid;
  assign b1.in_data = in_data;    assign b0.in_data = in_data;
  assign b4.in_data = in_data;
  assign b1.in_mode = in_mode;    assign b0.in_mode = in_mode;
  assign b4.in_mode = in_mode;
  assign b1.in_en = in_en;        assign b0.in_en = in_en;
  assign b4.in_en = in_en;
  assign b1.out_ready = out_ready; assign b0.out_ready = out_ready;
  assign b4.out_ready = out_ready;
  assign b1.ovf_clr = ovf_clr;    assign b0.ovf_clr = ovf_clr;
  assign b4.ovf_clr = ovf_clr;

  logic [2:0]    m_ir, m_ov;
  logic [DW-1:0] m_od [3];
  logic [L-1:0]  m_oo [3];
  logic [15:0]   m_cnt [3];

  assign m_ir = {b4.in_ready, b0.in_ready, b1.in_ready};
  assign m_ov = {b4.out_valid, b0.out_valid, b1.out_valid};
  assign m_od[0] = b1.out_data;  assign m_od[1] = b0.out_data;
  assign m_od[2] = b4.out_data;
  assign m_oo[0] = b1.out_ovf;   assign m_oo[1] = b0.out_ovf;
  assign m_oo[2] = b4.out_ovf;
  assign m_cnt[0] = b1.ovf_count;
  assign m_cnt[1] = b0.ovf_count;
  assign m_cnt[2] = {12'h000, b4.ovf_count};

  typedef struct {
    logic [DW-1:0] d;
    logic [L-1:0]  ovf;
  } exp_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    m;
    logic [L-1:0]  en;
    logic [DW-1:0] ys;
    logic [DW-1:0] yw;
    logic [L-1:0]  o;
  } vec_t;

  exp_t          q [3][$];
  int            sum [3];
  bit            stall [3];
  logic [DW-1:0] hd [3];
  logic [L-1:0]  ho [3];
  exp_t          mon_e;
  bit            cap;
  bit            saw_full;
  logic [15:0]   capq [$];
  int            checks = 0;
  int            errors = 0;

  function automatic bit sat_of(input int d);
    return d != 1;
  endfunction

  function automatic int cmax_of(input int d);
    return (d == 2) ? 15 : 65535;
  endfunction

  // Signed integer arithmetic: overflow is any result above +MAX
  function automatic exp_t model(input logic [DW-1:0] d,
                                 input logic [1:0] m,
                                 input logic [L-1:0] en,
                                 input bit sat);
    exp_t e;
    int v, r;
    logic [W-1:0] x;
    e.d = '0;
    e.ovf = '0;
    for (int i = 0; i < L; i++) begin
      x = d[i*W +: W];
      v = $signed(x);
      r = v;
      if (en[i]) begin
        case (m)
          2'd1: r = -v;
          2'd2: r = (v < 0) ? -v : v;
          2'd3: r = (v > 0) ? -v : v;
          default: r = v;
        endcase
      end
      if (r > 32767) begin
        e.ovf[i] = 1'b1;
        e.d[i*W +: W] = sat ? 16'h7FFF : r[W-1:0];
      end else begin
        e.d[i*W +: W] = r[W-1:0];
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int d,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", nm, d, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        q[d].delete();
        sum[d] = 0;
        stall[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (stall[d]) begin
          chk("stall_valid", d, DW'(m_ov[d]), 1);
          chk("stall_data", d, m_od[d], hd[d]);
          chk("stall_ovf", d, DW'(m_oo[d]), DW'(ho[d]));
        end
        if (in_valid && m_ir[d]) begin
          mon_e = model(in_data, in_mode, in_en, sat_of(d));
          q[d].push_back(mon_e);
          sum[d] += $countones(mon_e.ovf);
        end
        if (m_ov[d] && out_ready) begin
          if (q[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat dut%0d got %h want none",
                     d, m_od[d]);
          end else begin
            mon_e = q[d].pop_front();
            chk("beat_data", d, m_od[d], mon_e.d);
            chk("beat_ovf", d, DW'(m_oo[d]), DW'(mon_e.ovf));
          end
          if (cap && d == 0)
            capq.push_back(m_od[0][15:0]);
        end
        if (cap && d == 0 && !m_ir[0])
          saw_full = 1'b1;
        stall[d] = m_ov[d] && !out_ready;
        hd[d] = m_od[d];
        ho[d] = m_oo[d];
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [1:0] m,
                      input logic [L-1:0] en);
    int n;
    in_data  = d;
    in_mode  = m;
    in_en    = en;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_ir[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got %0d cycles want <200", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q[0].size() + q[1].size() + q[2].size() != 0 ||
            m_ov != 3'b000) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d cycles want <50", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string nm);
    int e;
    for (int d = 0; d < 3; d++) begin
      e = (sum[d] > cmax_of(d)) ? cmax_of(d) : sum[d];
      chk(nm, d, DW'(m_cnt[d]), DW'(e));
    end
  endtask

  task automatic chk_idle(input string nm);
    for (int d = 0; d < 3; d++) begin
      chk({nm, "_valid"}, d, DW'(m_ov[d]), 0);
      chk({nm, "_data"}, d, m_od[d], 0);
      chk({nm, "_ovf"}, d, DW'(m_oo[d]), 0);
      chk({nm, "_cnt"}, d, DW'(m_cnt[d]), 0);
      chk({nm, "_ready"}, d, DW'(m_ir[d]), 1);
    end
  endtask

  task automatic clear_cnt();
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    for (int d = 0; d < 3; d++) sum[d] = 0;
  endtask

  function automatic logic [W-1:0] rnd_lane();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h0000;
      2: return 16'h7FFF;
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  vec_t tv [8];
  logic [DW-1:0] pat;
  logic [DW-1:0] ovf4;
  bit acc;

  initial begin
    tv[0] = '{64'h7FFF_0000_FFFB_0005, 2'd1, 4'hF,
              64'h8001_0000_0005_FFFB, 64'h8001_0000_0005_FFFB, 4'h0};
    tv[1] = '{64'h7FFF_0000_FFFB_0005, 2'd2, 4'hF,
              64'h7FFF_0000_0005_0005, 64'h7FFF_0000_0005_0005, 4'h0};
    tv[2] = '{64'h7FFF_0000_FFFB_0005, 2'd3, 4'hF,
              64'h8001_0000_FFFB_FFFB, 64'h8001_0000_FFFB_FFFB, 4'h0};
    tv[3] = '{64'h7FFF_0000_FFFB_0005, 2'd0, 4'hF,
              64'h7FFF_0000_FFFB_0005, 64'h7FFF_0000_FFFB_0005, 4'h0};
    tv[4] = '{64'h8000_1234_8000_8000, 2'd1, 4'b1101,
              64'h7FFF_EDCC_8000_7FFF, 64'h8000_EDCC_8000_8000, 4'b1001};
    tv[5] = '{64'h8000_1234_8000_8000, 2'd3, 4'b1101,
              64'h8000_EDCC_8000_8000, 64'h8000_EDCC_8000_8000, 4'b0000};
    tv[6] = '{64'h8000_1234_8000_8000, 2'd1, 4'b1011,
              64'h7FFF_1234_7FFF_7FFF, 64'h8000_1234_8000_8000, 4'b1011};
    tv[7] = '{64'h8000_FFFF_0001_0000, 2'd2, 4'hF,
              64'h7FFF_0001_0001_0000, 64'h8000_0001_0001_0000, 4'b1000};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_mode = '0;
    in_en = '0;
    out_ready = 1'b1;
    ovf_clr = 1'b0;
    cap = 1'b0;
    saw_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");
    @(posedge clk);
    #1;

    // single beats: table values plus two-edge latency, one-cycle pulse
    for (int i = 0; i < 8; i++) begin
      send(tv[i].d, tv[i].m, tv[i].en);
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        chk("lat_early", d, DW'(m_ov[d]), 0);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk("lat_valid", d, DW'(m_ov[d]), 1);
        chk("vec_data", d, m_od[d], (d == 1) ? tv[i].yw : tv[i].ys);
        chk("vec_ovf", d, DW'(m_oo[d]), DW'(tv[i].o));
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        chk("lat_pulse", d, DW'(m_ov[d]), 0);
      @(posedge clk);
      #1;
    end
    drain();
    chk_cnt("cnt_table");
    chk("cnt_table_abs", 0, DW'(m_cnt[0]), 6);

    // backpressure: out_ready pattern 1,0,0 repeating
    cap = 1'b1;
    capq.delete();
    fork
      begin
        for (int k = 1; k <= 8; k++)
          send(DW'(k), 2'd1, 4'hF);
      end
      begin
        for (int c = 0; c < 60; c++) begin
          out_ready = (c % 3 == 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    cap = 1'b0;
    chk("bp_count", 0, DW'(capq.size()), 8);
    for (int k = 0; k < 8; k++) begin
      pat = (k < capq.size()) ? DW'(capq[k]) : '1;
      chk("bp_order", 0, pat, DW'(16'hFFFF - 16'(k)));
    end
    chk("bp_in_ready_fell", 0, DW'(saw_full), 1);

    // reset with both stages full
    out_ready = 1'b0;
    send(64'h0000_0000_0000_8000, 2'd1, 4'hF);
    send(64'h0000_0000_0000_0003, 2'd1, 4'hF);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk_idle("mid_rel");
    repeat (5) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        chk("no_stale", d, DW'(m_ov[d]), 0);
    end
    @(posedge clk);
    #1;

    // counter saturation: 5 beats x 4 overflowing lanes
    ovf4 = {4{16'h8000}};
    clear_cnt();
    for (int k = 0; k < 5; k++)
      send(ovf4, 2'd1, 4'hF);
    drain();
    chk_cnt("cnt_sat");
    chk("cnt_sat4", 2, DW'(m_cnt[2]), 15);
    chk("cnt_20", 0, DW'(m_cnt[0]), 20);

    // clear on the same edge as an overflowing S2 load
    send(ovf4, 2'd1, 4'hF);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    for (int d = 0; d < 3; d++) sum[d] = 0;
    drain();
    for (int d = 0; d < 3; d++)
      chk("cnt_clr_same", d, DW'(m_cnt[d]), 0);
    send(ovf4, 2'd2, 4'hF);
    drain();
    chk_cnt("cnt_resume");

    // random traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = in_valid && m_ir[0];
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < L; i++)
          in_data[i*W +: W] = rnd_lane();
        in_mode = 2'($urandom_range(0, 3));
        in_en = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drain();
    chk_cnt("cnt_rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
